// File: rtl/vga_timing_if.sv
// Video timing bundle: advance enable into the generator; syncs, blanking, counters and strobes out.
interface vga_timing_if #(
  parameter int unsigned CW  = 10,
  parameter int unsigned FCW = 8
);
  logic           en;
  logic           hsync;
  logic           vsync;
  logic           sync_b;
  logic           blank_b;
  logic [CW-1:0]  x;
  logic [CW-1:0]  y;
  logic           pix_ce;
  logic           line_start;
  logic           frame_start;
  logic [FCW-1:0] frame_cnt;

  modport master (
    input  en,
    output hsync, vsync, sync_b, blank_b, x, y,
    output pix_ce, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  hsync, vsync, sync_b, blank_b, x, y,
    input  pix_ce, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, x/y/frame counters and decoded sync/blank.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CW        = 10,
  parameter int unsigned FCW       = 8
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = 4;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Refuse to build a configuration whose totals overflow the counters.
  if (64'(H_TOTAL) >= (64'd1 << CW)) begin : g_bad_h_total
    $error("H_TOTAL does not fit in CW bits");
  end
  if (64'(V_TOTAL) >= (64'd1 << CW)) begin : g_bad_v_total
    $error("V_TOTAL does not fit in CW bits");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
    $error("CLK_DIV must be in 1..16");
  end

  logic [DW-1:0]  div_q;
  logic [CW-1:0]  x_q;
  logic [CW-1:0]  y_q;
  logic [FCW-1:0] frame_q;
  logic           pix_ce_c;
  logic           h_win_c;
  logic           v_win_c;

  // Gated by rst so no strobe escapes while the counters are being cleared.
  assign pix_ce_c = rst && vga.en && (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else if (vga.en) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      if (pix_ce_c) begin
        if (x_q == H_LAST) begin
          x_q <= '0;
          if (y_q == V_LAST) begin
            y_q     <= '0;
            frame_q <= frame_q + FCW'(1);
          end else begin
            y_q <= y_q + CW'(1);
          end
        end else begin
          x_q <= x_q + CW'(1);
        end
      end
    end
  end

  assign h_win_c = (x_q >= H_SS) && (x_q < H_SE);
  assign v_win_c = (y_q >= V_SS) && (y_q < V_SE);

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_cnt   = frame_q;
  assign vga.hsync       = h_win_c ? HSYNC_POL : ~HSYNC_POL;
  assign vga.vsync       = v_win_c ? VSYNC_POL : ~VSYNC_POL;
  assign vga.sync_b      = ~(h_win_c | v_win_c);
  assign vga.blank_b     = (x_q < H_ACT) && (y_q < V_ACT);
  assign vga.pix_ce      = pix_ce_c;
  assign vga.line_start  = pix_ce_c && (x_q == '0);
  assign vga.frame_start = pix_ce_c && (x_q == '0) && (y_q == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two scaled rasters plus the default raster, checked against closed-form timing.
module tb_vga_timing_gen;
  localparam int unsigned A_HA = 16, A_HF = 2, A_HS = 3, A_HB = 4;
  localparam int unsigned A_VA = 8,  A_VF = 1, A_VS = 2, A_VB = 3;
  localparam int unsigned A_DV = 2,  A_CW = 6, A_FW = 3;
  localparam int unsigned A_FRAME = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB) * A_DV;

  localparam int unsigned B_HA = 20, B_HF = 3, B_HS = 4, B_HB = 5;
  localparam int unsigned B_VA = 10, B_VF = 2, B_VS = 3, B_VB = 1;
  localparam int unsigned B_DV = 1,  B_CW = 6, B_FW = 4;
  localparam int unsigned B_FRAME = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB) * B_DV;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int unsigned t_a, t_b, t_c;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(A_CW), .FCW(A_FW)) ifa ();
  vga_timing_if #(.CW(B_CW), .FCW(B_FW)) ifb ();
  vga_timing_if #(.CW(10),   .FCW(8))    ifc ();

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(A_DV), .CW(A_CW), .FCW(A_FW)
  ) dut_a (.clk(clk), .rst(rst_a), .vga(ifa));

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(B_DV), .CW(B_CW), .FCW(B_FW)
  ) dut_b (.clk(clk), .rst(rst_b), .vga(ifb));

  vga_timing_gen dut_c (.clk(clk), .rst(rst_c), .vga(ifc));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack(input int unsigned f, y, x,
                                       input bit hs, vs, sb, bb, pc, ls, fs);
    return {9'd0, 16'(f), 16'(y), 16'(x), hs, vs, sb, bb, pc, ls, fs};
  endfunction

  // Expected outputs after t enabled clk cycles since reset, derived from the raster rules.
  function automatic logic [63:0] model(input int unsigned t, input bit rst, en,
                                        input int unsigned ha, hf, hs, hb, va, vf, vs, vb,
                                        input bit hp, vp, input int unsigned dv, fw);
    int unsigned ht, vt, p, x, ln, y, f;
    bit hw, vw, pc;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = t / dv;
    x  = p % ht;
    ln = p / ht;
    y  = ln % vt;
    f  = (ln / vt) % (32'd1 << fw);
    hw = (x >= ha + hf) && (x < ha + hf + hs);
    vw = (y >= va + vf) && (y < va + vf + vs);
    pc = rst && en && ((t % dv) == dv - 1);
    return pack(f, y, x, hw ? hp : !hp, vw ? vp : !vp, !(hw || vw),
                (x < ha) && (y < va), pc, pc && x == 0, pc && x == 0 && y == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    t_a = !rst_a ? 0 : (ifa.en ? t_a + 1 : t_a);
    t_b = !rst_b ? 0 : (ifb.en ? t_b + 1 : t_b);
    t_c = !rst_c ? 0 : (ifc.en ? t_c + 1 : t_c);
    @(negedge clk);
    cyc++;
    check("a_model",
          pack(32'(ifa.frame_cnt), 32'(ifa.y), 32'(ifa.x), ifa.hsync, ifa.vsync, ifa.sync_b,
               ifa.blank_b, ifa.pix_ce, ifa.line_start, ifa.frame_start),
          model(t_a, rst_a, ifa.en, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB,
                1'b0, 1'b0, A_DV, A_FW));
    check("b_model",
          pack(32'(ifb.frame_cnt), 32'(ifb.y), 32'(ifb.x), ifb.hsync, ifb.vsync, ifb.sync_b,
               ifb.blank_b, ifb.pix_ce, ifb.line_start, ifb.frame_start),
          model(t_b, rst_b, ifb.en, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB,
                1'b1, 1'b1, B_DV, B_FW));
    check("c_model",
          pack(32'(ifc.frame_cnt), 32'(ifc.y), 32'(ifc.x), ifc.hsync, ifc.vsync, ifc.sync_b,
               ifc.blank_b, ifc.pix_ce, ifc.line_start, ifc.frame_start),
          model(t_c, rst_c, ifc.en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 8));
  endtask

  initial begin
    int last_a, last_b, na, nb, hs_len, nhs, last_low_x;
    bit prev_blank, found;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.en = 1'b1; ifb.en = 1'b1; ifc.en = 1'b1;
    t_a = 0; t_b = 0; t_c = 0;
    repeat (3) tick();

    // Reset state with en held high.
    check("rst_x",        64'(ifa.x),         64'(0));
    check("rst_y",        64'(ifa.y),         64'(0));
    check("rst_fcnt",     64'(ifa.frame_cnt), 64'(0));
    check("rst_blank",    64'(ifa.blank_b),   64'(1));
    check("rst_hsync_a",  64'(ifa.hsync),     64'(1));
    check("rst_vsync_a",  64'(ifa.vsync),     64'(1));
    check("rst_hsync_b",  64'(ifb.hsync),     64'(0));
    check("rst_vsync_b",  64'(ifb.vsync),     64'(0));
    check("rst_syncb_b",  64'(ifb.sync_b),    64'(1));
    check("rst_pce_b",    64'(ifb.pix_ce),    64'(0));

    // Release: divide-by-1 strobes immediately, divide-by-2 one cycle later.
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    check("b_first_pce",    64'(ifb.pix_ce),      64'(1));
    check("b_first_fstart", 64'(ifb.frame_start), 64'(1));
    check("a_no_pce_yet",   64'(ifa.pix_ce),      64'(0));
    tick();
    check("a_first_pce",    64'(ifa.pix_ce),      64'(1));
    check("a_first_fstart", 64'(ifa.frame_start), 64'(1));

    // Frame periods, frame counter steps and wrap, default-raster line timing.
    last_a = cyc;     na = 1;
    last_b = cyc - 1; nb = 1;
    hs_len = 0; nhs = 0; last_low_x = 0; prev_blank = 1'b1;
    for (int i = 0; i < 6400; i++) begin
      tick();
      if (ifa.frame_start) begin
        check("a_frame_period", 64'(cyc - last_a), 64'(A_FRAME));
        check("a_fcnt_step",    64'(ifa.frame_cnt), 64'(na % 8));
        last_a = cyc; na++;
      end
      if (ifb.frame_start) begin
        check("b_frame_period", 64'(cyc - last_b), 64'(B_FRAME));
        check("b_fcnt_step",    64'(ifb.frame_cnt), 64'(nb % 16));
        last_b = cyc; nb++;
      end
      if (!ifc.hsync) begin
        if (hs_len == 0) check("c_hsync_first_x", 64'(ifc.x), 64'(656));
        hs_len++;
        last_low_x = int'(ifc.x);
      end else if (hs_len != 0) begin
        check("c_hsync_len_clk", 64'(hs_len), 64'(192));
        check("c_hsync_last_x",  64'(last_low_x), 64'(751));
        hs_len = 0; nhs++;
      end
      if (prev_blank && !ifc.blank_b) check("c_blank_fall_x", 64'(ifc.x), 64'(640));
      if (!prev_blank && ifc.blank_b) check("c_blank_rise_x", 64'(ifc.x), 64'(0));
      prev_blank = ifc.blank_b;
    end
    check("a_frames_seen",   64'(na),  64'(10));
    check("b_frames_seen",   64'(nb),  64'(13));
    check("c_hsync_pulses",  64'(nhs), 64'(4));

    // Pause mid-frame, then resume without losing a pixel.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = (ifa.x == A_CW'(10)) && (ifa.y == A_CW'(5));
    end
    check("a_reach_10_5", 64'(found), 64'(1));
    ifa.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hold_xy",      {32'(ifa.x), 32'(ifa.y)}, {32'd10, 32'd5});
      check("hold_strobes", 64'({ifa.pix_ce, ifa.line_start, ifa.frame_start}), 64'(0));
    end
    ifa.en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      found = (ifa.x != A_CW'(10));
    end
    check("resume_moved", 64'(found), 64'(1));
    check("resume_x",     64'(ifa.x), 64'(11));

    // Reset inside both sync windows restarts cleanly at the origin.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      found = (ifa.x == A_CW'(20)) && (ifa.y == A_CW'(10));
    end
    check("a_reach_20_10", 64'(found),     64'(1));
    check("pre_rst_hsync", 64'(ifa.hsync), 64'(0));
    check("pre_rst_vsync", 64'(ifa.vsync), 64'(0));
    rst_a = 1'b0;
    tick();
    check("mid_rst_xy",    {32'(ifa.x), 32'(ifa.y)}, 64'(0));
    check("mid_rst_hsync", 64'(ifa.hsync),     64'(1));
    check("mid_rst_vsync", 64'(ifa.vsync),     64'(1));
    check("mid_rst_fcnt",  64'(ifa.frame_cnt), 64'(0));
    rst_a = 1'b1;

    // Random enable gaps and occasional resets on every instance.
    for (int i = 0; i < 4000; i++) begin
      ifa.en = ($urandom_range(0, 3) != 0);
      ifb.en = ($urandom_range(0, 3) != 0);
      ifc.en = ($urandom_range(0, 3) != 0);
      rst_a  = ($urandom_range(0, 299) != 0);
      rst_b  = ($urandom_range(0, 299) != 0);
      rst_c  = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
